// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: operation codes, legality check, FSM states.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB, OP_NOR: op_legal = 1'b1;
      default:                                         op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: on a tie the requester that was not granted last wins.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared external ALU, one operation in flight,
// holding the ALU inputs for LATENCY cycles before capturing the result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [7:0]    req_op,
  input  logic [127:0]  req_a,
  input  logic [127:0]  req_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [63:0]   rsp_result,
  output logic          rsp_zero,
  output logic          rsp_err,
  output logic [3:0]    alu_operation,
  output logic [63:0]   alu_i0,
  output logic [63:0]   alu_i1,
  input  logic [63:0]   alu_out,
  input  logic          alu_zero,
  output logic          busy
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      state;
  logic        last;
  logic [3:0]  cnt;
  logic [1:0]  grant;
  logic        hs;
  logic        sel;
  logic [3:0]  sel_op;
  logic [63:0] sel_a;
  logic [63:0] sel_b;

  rr_arbiter_2 u_rr (
    .req   (req_valid),
    .last  (last),
    .grant (grant)
  );

  // Gated by rst_n so every output reads 0 while reset is held.
  assign req_ready = (state == ST_IDLE && rst_n) ? grant : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign sel       = req_ready[1];
  assign sel_op    = sel ? req_op[7:4]   : req_op[3:0];
  assign sel_a     = sel ? req_a[127:64] : req_a[63:0];
  assign sel_b     = sel ? req_b[127:64] : req_b[63:0];
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      last          <= 1'b1;
      cnt           <= '0;
      alu_operation <= '0;
      alu_i0        <= '0;
      alu_i1        <= '0;
      rsp_id        <= 1'b0;
      rsp_result    <= '0;
      rsp_zero      <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (hs) begin
          last   <= sel;
          rsp_id <= sel;
          if (op_legal(sel_op)) begin
            alu_operation <= sel_op;
            alu_i0        <= sel_a;
            alu_i1        <= sel_b;
            cnt           <= LAT_M1;
            state         <= ST_EXEC;
          end else begin
            // Illegal ops bypass the ALU entirely; its drive registers stay as they were.
            rsp_err    <= 1'b1;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            state      <= ST_RESP;
          end
        end
        ST_EXEC: if (cnt == 4'd0) begin
          rsp_result <= alu_out;
          rsp_zero   <= alu_zero;
          rsp_err    <= 1'b0;
          state      <= ST_RESP;
        end else begin
          cnt <= cnt - 4'd1;
        end
        ST_RESP: if (rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized + directed bench for alu_arbiter against a transaction-level model.
module tb_alu_arbiter;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [7:0]   req_op = '0;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic         rsp_id;
  logic [63:0]  rsp_result;
  logic         rsp_zero;
  logic         rsp_err;
  logic [3:0]   alu_operation;
  logic [63:0]  alu_i0;
  logic [63:0]  alu_i1;
  logic [63:0]  alu_out;
  logic         alu_zero;
  logic         busy;

  always #5 clk = ~clk;

  alu_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_operation(alu_operation), .alu_i0(alu_i0), .alu_i1(alu_i1),
    .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
  );

  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      4'b1100: return ~(a | b);
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
  endfunction

  function automatic logic [1:0] rr(input logic [1:0] v, input bit lst);
    if (v == 2'b11) return lst ? 2'b01 : 2'b10;
    return v;
  endfunction

  assign alu_out  = alu_fn(alu_operation, alu_i0, alu_i1);
  assign alu_zero = (alu_out == 64'd0);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {bit id; bit err; bit zero; logic [63:0] res;} rsp_t;
  rsp_t rlog[$];

  // Transaction-level model state.
  int          cyc = 0;
  int          m_due = 0;
  bit          m_busy = 0, m_last = 1, m_id = 0, m_err = 0, m_zero = 0;
  logic [63:0] m_res = '0;
  logic [3:0]  m_op = '0;
  logic [63:0] m_a = '0, m_b = '0;

  task automatic set_req(input int n, input bit v, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    req_valid[n]      = v;
    req_op[n*4 +: 4]  = op;
    req_a[n*64 +: 64] = a;
    req_b[n*64 +: 64] = b;
  endtask

  // Called just after a rising edge; checks at the falling edge, advances the model at the next rise.
  task automatic tick();
    logic [1:0] g, hs;
    bit         rv, consume;
    rsp_t       obs;
    int         s;
    logic [3:0] op;
    logic [63:0] a, b;
    @(negedge clk);
    g  = m_busy ? 2'b00 : rr(req_valid, m_last);
    rv = m_busy && (cyc >= m_due);
    chk("req_ready", 64'(req_ready), 64'(g));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("rsp_valid", 64'(rsp_valid), 64'(rv));
    if (rv) begin
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_zero", 64'(rsp_zero), 64'(m_zero));
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
    end
    chk("alu_operation", 64'(alu_operation), 64'(m_op));
    chk("alu_i0", alu_i0, m_a);
    chk("alu_i1", alu_i1, m_b);
    obs = '{rsp_id, rsp_err, rsp_zero, rsp_result};
    consume = rv && rsp_ready;
    hs = req_valid & g;
    s  = hs[1] ? 1 : 0;
    op = req_op[s*4 +: 4];
    a  = req_a[s*64 +: 64];
    b  = req_b[s*64 +: 64];
    @(posedge clk);
    cyc++;
    if (consume) begin
      m_busy = 0;
      rlog.push_back(obs);
    end
    if (hs != 2'b00) begin
      m_busy = 1; m_last = s[0]; m_id = s[0];
      if (legal(op)) begin
        m_op = op; m_a = a; m_b = b;
        m_res = alu_fn(op, a, b); m_zero = (m_res == 64'd0); m_err = 0;
        m_due = cyc + LAT;
      end else begin
        m_res = '0; m_zero = 0; m_err = 1;
        m_due = cyc;
      end
    end
    #1;
    if (hs != 2'b00) req_valid[s] = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("rst req_ready", 64'(req_ready), 64'd0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst rsp_id", 64'(rsp_id), 64'd0);
    chk("rst rsp_result", rsp_result, 64'd0);
    chk("rst rsp_zero", 64'(rsp_zero), 64'd0);
    chk("rst rsp_err", 64'(rsp_err), 64'd0);
    chk("rst alu_operation", 64'(alu_operation), 64'd0);
    chk("rst alu_i0", alu_i0, 64'd0);
    chk("rst alu_i1", alu_i1, 64'd0);
    m_busy = 0; m_last = 1; m_op = '0; m_a = '0; m_b = '0;
    req_valid = 2'b00;
    @(posedge clk);
    cyc++;
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_rsp(input string tag, input int idx, input bit id, input bit err, input bit zero, input logic [63:0] res);
    if (rlog.size() <= idx) begin
      chk({tag, " count"}, 64'(rlog.size()), 64'(idx + 1));
    end else begin
      chk({tag, " id"}, 64'(rlog[idx].id), 64'(id));
      chk({tag, " err"}, 64'(rlog[idx].err), 64'(err));
      chk({tag, " zero"}, 64'(rlog[idx].zero), 64'(zero));
      chk({tag, " res"}, rlog[idx].res, res);
    end
  endtask

  logic [3:0] legal_ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

  initial begin
    @(posedge clk);
    #1 pulse_reset();

    // Single ADD from requester 0.
    rlog.delete();
    rsp_ready = 1'b1;
    set_req(0, 1, 4'b0010, 64'd5, 64'd7);
    repeat (LAT + 4) tick();
    chk_rsp("add", 0, 0, 0, 0, 64'd12);

    // Tie straight out of reset: requester 0 first, then requester 1.
    pulse_reset();
    rlog.delete();
    set_req(0, 1, 4'b0110, 64'd9, 64'd9);
    set_req(1, 1, 4'b0001, 64'hF0, 64'h0F);
    repeat (2 * (LAT + 3)) tick();
    chk_rsp("tie0", 0, 0, 0, 1, 64'd0);
    chk_rsp("tie1", 1, 1, 0, 0, 64'hFF);

    // Illegal op code from requester 1.
    rlog.delete();
    set_req(1, 1, 4'b0011, 64'd3, 64'd4);
    repeat (3) tick();
    chk_rsp("illegal", 0, 1, 1, 0, 64'd0);

    // Back-pressure on the response while the other requester waits.
    rlog.delete();
    rsp_ready = 1'b0;
    set_req(0, 1, 4'b0111, 64'd1, 64'hABCD);
    tick();
    set_req(1, 1, 4'b0000, 64'hFF, 64'h0F);
    repeat (LAT + 3) tick();
    rsp_ready = 1'b1;
    repeat (LAT + 4) tick();
    chk_rsp("hold0", 0, 0, 0, 0, 64'hABCD);
    chk_rsp("hold1", 1, 1, 0, 0, 64'h0F);

    // Reset mid-EXEC, then a tie must go to requester 0.
    rlog.delete();
    set_req(1, 1, 4'b0010, 64'd1, 64'd1);
    repeat (2) tick();
    pulse_reset();
    set_req(0, 1, 4'b1100, 64'd0, 64'd0);
    set_req(1, 1, 4'b0001, 64'd2, 64'd2);
    repeat (LAT + 3) tick();
    chk_rsp("post_rst", 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 2; n++) begin
        logic [3:0]  op;
        logic [63:0] a, b;
        op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : legal_ops[$urandom_range(0, 5)];
        a  = {$urandom, $urandom};
        b  = ($urandom_range(0, 5) == 0) ? a : {$urandom, $urandom};
        set_req(n, bit'($urandom_range(0, 1)), op, a, b);
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: LATENCY, default 1, number of EXEC cycles allowed for the shared ALU result to settle (legal range 1..15).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 Port: req_valid  in  2  bit N = requester N has an operation pending.
REQ-005 Port: req_ready  out  2  bit N = arbiter accepts requester N this cycle.
REQ-006 Port: req_op  in  8  [4N+3:4N] = 4-bit ALU operation code of requester N.
REQ-007 Port: req_a  in  128  [64N+63:64N] = operand i0 of requester N.
REQ-008 Port: req_b  in  128  [64N+63:64N] = operand i1 of requester N.
REQ-009 Port: rsp_valid  out  1  response available.
REQ-010 Port: rsp_ready  in  1  consumer accepts the response.
REQ-011 Port: rsp_id  out  1  requester index owning the response.
REQ-012 Port: rsp_result  out  64  ALU result.
REQ-013 Port: rsp_zero  out  1  ALU zero flag for the result.
REQ-014 Port: rsp_err  out  1  operation code was illegal; result not computed.
REQ-015 Port: alu_operation / alu_i0 / alu_i1  out  4 / 64 / 64  drive the shared ALU.
REQ-016 Port: alu_out / alu_zero  in  64 / 1  shared ALU result and zero flag.
REQ-017 Port: busy  out  1  high whenever FSM is not IDLE.

Function
REQ-018 FSM SHALL have states IDLE, EXEC, RESP; exactly one operation in flight.
REQ-019 In IDLE, req_ready SHALL be one-hot to the granted requester among those with req_valid high, otherwise 0; req_ready SHALL be 0 in EXEC and RESP.
REQ-020 Grant SHALL be round-robin: when both valid, the requester not granted last wins; single valid wins outright.
REQ-021 On handshake (req_valid[N] & req_ready[N]) the arbiter SHALL register op, a, b, and id N, and update the last-granted pointer.
REQ-022 Legal op codes SHALL be 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS-B, 1100 NOR.
REQ-023 Legal op: IDLE->EXEC; EXEC SHALL last exactly LATENCY cycles with alu_operation/alu_i0/alu_i1 held from registers.
REQ-024 On the final EXEC edge, alu_out and alu_zero SHALL be captured into rsp_result/rsp_zero with rsp_err=0; FSM->RESP.
REQ-025 Illegal op: IDLE->RESP directly, rsp_err=1, rsp_result=0, rsp_zero=0; ALU drive registers unchanged.
REQ-026 Timing: handshake at edge T SHALL give rsp_valid high after edge T+LATENCY (legal) or after edge T (illegal).
REQ-027 In RESP, rsp_valid SHALL be 1 and all rsp_* stable until rsp_ready; on rsp_valid & rsp_ready the FSM SHALL return to IDLE.
REQ-028 A new request SHALL NOT be accepted in the cycle the response is consumed; earliest next accept is the following IDLE cycle.
REQ-029 Requesters hold req_valid/op/operands until handshake; changes before handshake SHALL be honored, never latched early.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, all outputs 0 (alu_operation=0000), last-granted pointer=1 (requester 0 wins first tie).
REQ-031 Reset during EXEC or RESP SHALL discard the in-flight operation; no response is produced afterwards.

Structure
REQ-032 Shared package alu_pkg SHALL hold op code constants, the op-legality function and the FSM state enum.
REQ-033 Grant logic SHALL be sub-module rr_arbiter_2 (2-way round-robin, pointer input, one-hot grant output); the ALU is instantiated outside.

Verification
REQ-034 Req0 ADD a=5 b=7, LATENCY=1 -> rsp_valid 2 edges after accept, rsp_id=0, result=12, zero=0, err=0.
REQ-035 Both valid from reset, req0 SUB 9-9, req1 OR 0xF0|0x0F -> req0 first (result 0, zero=1), then req1 (0xFF, id=1).
REQ-036 Req1 op 0011 -> rsp_err=1, result=0, rsp_valid 1 edge after accept, alu_* unchanged.
REQ-037 LATENCY=4, rsp_ready held low 3 cycles -> rsp stable, req_ready=00 throughout, busy=1 until consume.
REQ-038 rst_n pulsed low mid-EXEC -> outputs 0 at once, no rsp_valid afterwards, next tie goes to req0.
